instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch stage that drives the instruction cache request port and feeds decode. It holds the program counter and issues one cache read at a time using the cache's level handshake (`read_enable`/`send_enable`). Returned instructions are tagged with their PC and buffered in a small FIFO toward decode. Branch/jump redirects from execute flush the FIFO and squash any in-flight read.

## Interface
- `reset_pc`, default 64'h0: PC loaded on reset; bits [1:0] are treated as 0.
- `queue_depth`, default 4: number of FIFO entries; power of two, ≥2.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in 64: new PC; bits [1:0] are forced to 0.
- `read_enable` out 1: cache request; registered.
- `address` out 64: request address; registered, stable for the whole request.
- `icache_data` in 32: instruction word from cache; valid while `send_enable`=1.
- `send_enable` in 1: cache data valid; level signal, held until `read_enable` drops.
- `decode_valid` out 1: FIFO not empty.
- `decode_instr` out 32: head instruction; 0 when empty.
- `decode_pc` out 64: head PC; 0 when empty.
- `decode_ready` in 1: decode accepts head when `decode_valid`=1.

## Operation
- State machine with three states:
  - IDLE: `read_enable`=0.
  - REQUEST: `read_enable`=1, waiting for `send_enable`=1.
  - RELEASE: `read_enable`=0, waiting for `send_enable`=0.
- Registers:
  - `fetch_pc`: next PC to fetch.
  - `req_pc`: drives `address`.
  - `squash`: discards the returning word of a redirected read.
  - FIFO with `count` (0..queue_depth).
- Transitions:
  - IDLE → REQUEST when `count` (after this cycle's pop) < queue_depth and no redirect. On entry, `req_pc` <= `fetch_pc`.
  - REQUEST → RELEASE when `send_enable`=1.
    - If `squash`=0 and no redirect this cycle: push {`req_pc`, `icache_data`}, `fetch_pc` <= `req_pc`+4.
    - Otherwise: drop the word and clear `squash`.
  - RELEASE → REQUEST when `send_enable`=0, room is available, and no redirect. Otherwise RELEASE → IDLE when `send_enable`=0.
- Redirect (highest priority, any state):
  - `fetch_pc` <= `redirect_pc`.
  - FIFO flushed (`count`=0; pop and push that cycle are ignored).
  - In REQUEST with `send_enable`=0: `squash` <= 1 and the state is unchanged. An in-flight cache read is never abandoned, because `address` must stay stable until the cache finishes.
  - In IDLE/RELEASE: the normal transition applies, but a new REQUEST cannot start in the redirect cycle.
- Pop: on `decode_valid && decode_ready`. Push and pop in the same cycle leave `count` unchanged.
- At most one read is outstanding. A request starts only with a free slot, so a push never overflows.
- PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - Outputs: `read_enable`=0, `address`=`reset_pc`, `decode_valid`=0, `decode_instr`=0, `decode_pc`=0.
  - Internal: state IDLE, `count`=0, `squash`=0, `fetch_pc`=`reset_pc`.
- Reset mid-request: everything returns to reset values immediately and `read_enable` falls asynchronously. The cache is expected to be reset by the same signal.
- First `read_enable`=1 appears on the first rising edge after reset deasserts.
- Capture edge (REQUEST, `send_enable`=1): at the same edge, `read_enable` goes 0 and the pushed entry sets `decode_valid`=1. Fetch-to-decode adds 0 extra cycles beyond cache latency.
- Back-to-back hits: REQUEST(capture) → RELEASE (1 cycle minimum, until the cache drops `send_enable`) → REQUEST. This gives at least 2 edges between successive `read_enable` rises.
- `address` changes only on the edge entering REQUEST.
- `decode_*` outputs are combinational from the FIFO head register, not from inputs.

## Test plan
- **Sequential fetch.** Stimulus: `reset_pc`=0x1000; cache hits with 1-cycle `send_enable`; `decode_ready`=1. Response: `decode_pc` = 0x1000, 0x1004, 0x1008…, each paired with the matching word; `address` stable during each request.
- **Backpressure.** Stimulus: `decode_ready`=0; queue_depth=4. Response: exactly 4 captures, `count`=4, state IDLE with `read_enable`=0. Raising `decode_ready` for one cycle produces exactly one new request with `address`=0x1010.
- **Redirect mid-miss.** Stimulus: `redirect_valid` at 0x2000 while in REQUEST with `send_enable`=0. Response: FIFO empty, `address` unchanged until `send_enable`; returned word discarded; next `address`=0x2000.
- **Redirect coincident with capture.** Stimulus: `redirect_valid` and `send_enable` in the same cycle. Response: word dropped, `decode_valid`=0, next request `address`=`redirect_pc`, `squash`=0.
- **Wrap-around.** Stimulus: redirect to 64'hFFFF_FFFF_FFFF_FFFC. Response: next fetch `address`=0. A misaligned `redirect_pc`=0x3003 fetches 0x3000.
- **Reset mid-operation.** Stimulus: assert `reset` during REQUEST with 2 entries queued. Response: `read_enable`=0 and `decode_valid`=0 immediately; after release, first `address`=`reset_pc`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end.
// Holds the program counter and issues one level-handshake read at a time to
// the instruction cache. Each returned word is tagged with its PC and queued
// toward decode. A redirect from execute flushes the queue and squashes a
// read that is still in flight.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        read_enable,
    output logic [63:0] address,
    input  logic [31:0] icache_data,
    input  logic        send_enable,
    output logic        decode_valid,
    output logic [31:0] decode_instr,
    output logic [63:0] decode_pc,
    input  logic        decode_ready
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    localparam logic [63:0]      RESET_PC_ALIGNED = RESET_PC & ~64'h3;
    localparam logic [CNT_W-1:0] DEPTH_CNT        = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no request on the cache port
        ST_REQUEST = 2'd1,  // read_enable high, waiting for send_enable
        ST_RELEASE = 2'd2   // read_enable low, waiting for send_enable to drop
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [63:0]       r_fetch_pc;
    logic [63:0]       r_req_pc;
    logic              r_squash;
    logic              r_read_enable;

    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [31:0]       r_fifo_instr [QUEUE_DEPTH];
    logic [63:0]       r_fifo_pc    [QUEUE_DEPTH];

    logic [63:0]       w_redirect_pc_aligned;
    logic              w_empty;
    logic              w_pop;
    logic              w_capture;
    logic              w_push;
    logic [CNT_W-1:0]  w_count_after_pop;
    logic              w_room;
    logic              w_start_ok;
    logic              w_enter_request;

    assign w_redirect_pc_aligned = redirect_pc & ~64'h3;
    assign w_empty               = (r_count == '0);

    // A redirect flushes the queue, so neither a pop nor a push survives it.
    assign w_pop     = !w_empty && decode_ready && !redirect_valid;
    assign w_capture = (r_state == ST_REQUEST) && send_enable;
    assign w_push    = w_capture && !r_squash && !redirect_valid;

    // A new read may only start when the word it returns is certain to fit,
    // counting the slot freed by this cycle's pop.
    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_room            = (w_count_after_pop < DEPTH_CNT);
    assign w_start_ok        = w_room && !redirect_valid;

    assign w_enter_request = (r_state != ST_REQUEST) && (w_state_next == ST_REQUEST);

    // Next-state selection for the cache handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // The read is never abandoned: the address must stay put
                // until the cache answers, even across a redirect.
                if (send_enable) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!send_enable) begin
                    w_state_next = w_start_ok ? ST_REQUEST : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered cache request signals.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_read_enable <= 1'b0;
            r_req_pc      <= RESET_PC_ALIGNED;
        end else begin
            r_state       <= w_state_next;
            r_read_enable <= (w_state_next == ST_REQUEST);
            if (w_enter_request) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    // Program counter: redirect wins, otherwise advance on each accepted word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc_aligned;
        end else if (w_push) begin
            r_fetch_pc <= r_req_pc + 64'd4;
        end
    end

    // Squash flag: set when a redirect hits an unanswered read, cleared when
    // that read's word comes back (and is dropped).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_squash <= 1'b0;
        end else if (w_capture) begin
            r_squash <= 1'b0;
        end else if (redirect_valid && (r_state == ST_REQUEST)) begin
            r_squash <= 1'b1;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue outright.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Queue storage: the returned word and the PC it was fetched from.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= icache_data;
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

    assign read_enable  = r_read_enable;
    assign address      = r_req_pc;

    // Decode sees the queue head directly; an empty queue presents zeros.
    assign decode_valid = !w_empty;
    assign decode_instr = w_empty ? 32'd0 : r_fifo_instr[r_rd_ptr];
    assign decode_pc    = w_empty ? 64'd0 : r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a behavioural cache drives the request
// port, and a queue-of-PCs model predicts what decode must see.
module tb_instruction_fetch_unit;

    localparam logic [63:0] RPC   = 64'h1000;
    localparam int          DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        read_enable;
    logic [63:0] address;
    logic [31:0] icache_data;
    logic        send_enable;
    logic        decode_valid;
    logic [31:0] decode_instr;
    logic [63:0] decode_pc;
    logic        decode_ready;

    instruction_fetch_unit #(
        .RESET_PC    (RPC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .read_enable    (read_enable),
        .address        (address),
        .icache_data    (icache_data),
        .send_enable    (send_enable),
        .decode_valid   (decode_valid),
        .decode_instr   (decode_instr),
        .decode_pc      (decode_pc),
        .decode_ready   (decode_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: PCs that decode should see, in order.
    logic [63:0] m_q [$];
    logic [63:0] m_fetch;
    bit          m_squash;

    // Cache model state and bookkeeping.
    bit          c_send;
    int          c_lat;
    int          lat_lo;
    int          lat_hi;
    int          hold_pct;
    logic        prev_re;
    logic [63:0] prev_addr;
    bit          prev_capture;
    int          rise_cnt;
    int          pop_cnt;
    logic [63:0] rise_log [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32] ^ 32'h5A5A_0001;
    endfunction

    function automatic logic [63:0] get_rise(input int idx);
        if (rise_log.size() > idx) return rise_log[idx];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    // rmode: 0 none, 1 redirect now, 2 only on a capture cycle,
    //        3 only while a read waits, 4 random.
    task automatic step(input bit rdy, input int rmode, input logic [63:0] rpc, output bit fired);
        logic        re;
        logic        dv;
        logic [63:0] addr;
        logic [63:0] dpc;
        logic [31:0] di;
        bit          redir;
        bit          pop;
        bit          cap;
        re   = read_enable;
        addr = address;
        dv   = decode_valid;
        di   = decode_instr;
        dpc  = decode_pc;

        chk("valid", 64'(dv), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("head_pc", dpc, m_q[0]);
            chk("head_instr", 64'(di), 64'(mem_word(m_q[0])));
        end else begin
            chk("empty_instr", 64'(di), 64'd0);
            chk("empty_pc", dpc, 64'd0);
        end
        if (prev_capture) chk("re_drop", 64'(re), 64'd0);
        if (re && !prev_re) begin
            rise_cnt++;
            rise_log.push_back(addr);
            chk("req_addr", addr, m_fetch);
            chk("req_room", 64'(m_q.size() < DEPTH), 64'd1);
            c_lat = $urandom_range(lat_hi, lat_lo);
        end else if (re && prev_re) begin
            chk("addr_stable", addr, prev_addr);
        end

        // Cache: answer after the chosen latency, hold until read_enable drops.
        if (c_send) begin
            if (!re && ($urandom_range(99, 0) >= hold_pct)) c_send = 1'b0;
        end else if (re) begin
            if (c_lat == 0) c_send = 1'b1;
            else c_lat--;
        end
        send_enable = c_send;
        icache_data = c_send ? mem_word(addr) : $urandom();

        case (rmode)
            1:       redir = 1'b1;
            2:       redir = re && c_send;
            3:       redir = re && !c_send;
            4:       redir = ($urandom_range(99, 0) < 4);
            default: redir = 1'b0;
        endcase
        fired          = redir;
        redirect_valid = redir;
        redirect_pc    = rpc;
        decode_ready   = rdy;

        pop = dv && rdy && !redir;
        cap = re && c_send;
        if (redir) begin
            m_q.delete();
            m_fetch = rpc & ~64'h3;
            if (cap) m_squash = 1'b0;
            else if (re) m_squash = 1'b1;
        end else begin
            if (pop && m_q.size() != 0) begin
                $display("pop pc=%h instr=%h", m_q[0], di);
                void'(m_q.pop_front());
                pop_cnt++;
            end
            if (cap) begin
                if (m_squash) begin
                    m_squash = 1'b0;
                end else begin
                    m_q.push_back(addr);
                    m_fetch = addr + 64'd4;
                end
            end
        end
        prev_re      = re;
        prev_addr    = addr;
        prev_capture = cap;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asserts reset wherever we are, checks reset values, releases it on a
    // falling edge and checks the first request appears on the next edge.
    task automatic do_reset();
        reset          = 1'b1;
        c_send         = 1'b0;
        c_lat          = 0;
        send_enable    = 1'b0;
        icache_data    = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        decode_ready   = 1'b0;
        m_q.delete();
        m_fetch      = RPC;
        m_squash     = 1'b0;
        prev_re      = 1'b0;
        prev_addr    = RPC;
        prev_capture = 1'b0;
        #1;
        chk("rst_re", 64'(read_enable), 64'd0);
        chk("rst_dv", 64'(decode_valid), 64'd0);
        @(negedge clock);
        chk("rst_addr", address, RPC);
        chk("rst_instr", 64'(decode_instr), 64'd0);
        chk("rst_pc", decode_pc, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("first_re", 64'(read_enable), 64'd1);
    endtask

    initial begin
        bit          f;
        bit          ok;
        logic [63:0] rpc;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        icache_data    = 32'd0;
        send_enable    = 1'b0;
        decode_ready   = 1'b0;
        lat_lo = 0; lat_hi = 0; hold_pct = 0;
        rise_cnt = 0; pop_cnt = 0;
        #1;
        do_reset();

        // Backpressure: exactly DEPTH captures, then idle.
        rise_cnt = 0;
        repeat (30) step(1'b0, 0, 64'd0, f);
        chk("bp_captures", 64'(rise_cnt), 64'd4);
        chk("bp_re", 64'(read_enable), 64'd0);
        chk("bp_dv", 64'(decode_valid), 64'd1);
        chk("bp_head", decode_pc, 64'h1000);
        rise_cnt = 0;
        rise_log.delete();
        step(1'b1, 0, 64'd0, f);
        repeat (20) step(1'b0, 0, 64'd0, f);
        chk("bp_one_req", 64'(rise_cnt), 64'd1);
        chk("bp_addr", get_rise(0), 64'h1010);

        // Sequential fetch with decode always ready.
        pop_cnt = 0;
        repeat (40) step(1'b1, 0, 64'd0, f);
        chk("seq_pops", 64'(pop_cnt >= 10), 64'd1);

        // Redirect while a read is still waiting for the cache.
        lat_lo = 3; lat_hi = 3;
        f = 1'b0;
        for (int i = 0; i < 200 && !f; i++) step(1'b1, 3, 64'h2000, f);
        chk("midmiss_fired", 64'(f), 64'd1);
        chk("midmiss_dv", 64'(decode_valid), 64'd0);
        rise_log.delete();
        for (int i = 0; i < 100 && rise_log.size() < 1; i++) step(1'b1, 0, 64'd0, f);
        chk("midmiss_next", get_rise(0), 64'h2000);

        // Redirect on the very edge the word returns.
        lat_lo = 1; lat_hi = 1;
        f = 1'b0;
        for (int i = 0; i < 200 && !f; i++) step(1'b1, 2, 64'h2400, f);
        chk("coinc_fired", 64'(f), 64'd1);
        chk("coinc_dv", 64'(decode_valid), 64'd0);
        rise_log.delete();
        pop_cnt = 0;
        for (int i = 0; i < 100 && pop_cnt < 1; i++) step(1'b1, 0, 64'd0, f);
        chk("coinc_next", get_rise(0), 64'h2400);
        chk("coinc_pop", 64'(pop_cnt), 64'd1);

        // PC wrap-around and misaligned redirect.
        lat_lo = 0; lat_hi = 0;
        step(1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFC, f);
        rise_log.delete();
        for (int i = 0; i < 100 && rise_log.size() < 2; i++) step(1'b1, 0, 64'd0, f);
        chk("wrap_first", get_rise(0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_zero", get_rise(1), 64'h0);
        step(1'b1, 1, 64'h3003, f);
        rise_log.delete();
        for (int i = 0; i < 100 && rise_log.size() < 1; i++) step(1'b1, 0, 64'd0, f);
        chk("misalign", get_rise(0), 64'h3000);

        // Reset during a request with two entries queued.
        lat_lo = 8; lat_hi = 8;
        step(1'b0, 1, 64'h5000, f);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step(1'b0, 0, 64'd0, f);
            ok = read_enable && !send_enable && (m_q.size() == 2);
        end
        chk("mo_setup", 64'(ok), 64'd1);
        #2;
        do_reset();
        chk("mo_addr", address, RPC);
        lat_lo = 0; lat_hi = 2;
        repeat (20) step(1'b1, 0, 64'd0, f);

        // Randomized traffic.
        lat_lo = 0; lat_hi = 3; hold_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(3, 0) == 0) rpc[63:8] = '1;
            step(($urandom_range(9, 0) < 7), 4, rpc, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
